// File: rtl/rr_mux_arb.sv
// rr_mux_arb: N-channel registered mux with valid/ready handshakes.
// MODE 0 picks the channel from sel; MODE 1 round-robins requesters.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_data  [N_CH*WIDTH]  channel i at [i*WIDTH +: WIDTH]
//   in_valid [N_CH]        per-channel valid
//   in_ready [N_CH]        per-channel accept (combinational)
//   sel      [SELW]        channel select (MODE 0 only)
//   out_data [WIDTH]       registered output word
//   out_ch   [SELW]        source channel of out_data
//   out_valid, out_ready   output handshake
module rr_mux_arb #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int MODE  = 0,
    parameter int SELW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    input  logic [SELW-1:0]       sel,
    output logic [WIDTH-1:0]      out_data,
    output logic [SELW-1:0]       out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [N_CH-1:0]  grant;
    logic             can_load;
    logic             accept;
    logic [WIDTH-1:0] pick_data;
    logic [SELW-1:0]  pick_ch;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_ch_q, out_ch_d;

    // Output register can take a word when empty or draining this cycle.
    assign can_load = !out_valid_q || out_ready;
    assign in_ready = rst_n ? (grant & {N_CH{can_load}}) : '0;
    assign accept   = |(in_ready & in_valid);

    // grant is one-hot or zero, so an OR-style pick is safe.
    always_comb begin
        pick_data = '0;
        pick_ch   = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                pick_data = in_data[i*WIDTH +: WIDTH];
                pick_ch   = SELW'(i);
            end
        end
    end

    generate
        if (MODE == 0) begin : g_sel
            // Out-of-range sel matches no channel, so nothing is granted.
            always_comb begin
                grant = '0;
                for (int i = 0; i < N_CH; i++) begin
                    grant[i] = (int'(sel) == i);
                end
            end
        end else begin : g_rr
            logic [SELW-1:0] ptr_q, ptr_d;
            logic            found;
            logic            unused_sel;

            assign unused_sel = ^sel;

            // Search above the pointer first, then wrap to the
            // channels at or below it: priority starts at ptr+1.
            always_comb begin
                grant = '0;
                found = 1'b0;
                for (int i = 0; i < N_CH; i++) begin
                    if (!found && in_valid[i] && (i > int'(ptr_q))) begin
                        grant[i] = 1'b1;
                        found    = 1'b1;
                    end
                end
                for (int i = 0; i < N_CH; i++) begin
                    if (!found && in_valid[i] && (i <= int'(ptr_q))) begin
                        grant[i] = 1'b1;
                        found    = 1'b1;
                    end
                end
            end

            // Pointer only moves on a real transfer, so a stalled
            // requester keeps its turn.
            assign ptr_d = accept ? pick_ch : ptr_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ptr_q <= SELW'(N_CH - 1);
                end else begin
                    ptr_q <= ptr_d;
                end
            end
        end
    endgenerate

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = pick_data;
            out_ch_d    = pick_ch;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_mux_arb.sv
// tb_rr_mux_arb: self-checking bench for rr_mux_arb in MODE 0 / MODE 1
// and a 3-channel MODE 0 build; table rows plus reset sequences.
module tb_rr_mux_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [31:0] din;
    logic [3:0]  v0, v1, r0, r1;
    logic [1:0]  s0, s1, c0, c1;
    logic [7:0]  d0o, d1o;
    logic        ov0, ov1, or0, or1;

    logic [23:0] din3;
    logic [2:0]  v3, r3;
    logic [1:0]  s3, c3;
    logic [7:0]  d3o;
    logic        ov3, or3;

    rr_mux_arb #(.N_CH(4), .WIDTH(8), .MODE(0)) u_m0 (
        .clk(clk), .rst_n(rst_n), .in_data(din), .in_valid(v0),
        .in_ready(r0), .sel(s0), .out_data(d0o), .out_ch(c0),
        .out_valid(ov0), .out_ready(or0)
    );

    rr_mux_arb #(.N_CH(4), .WIDTH(8), .MODE(1)) u_m1 (
        .clk(clk), .rst_n(rst_n), .in_data(din), .in_valid(v1),
        .in_ready(r1), .sel(s1), .out_data(d1o), .out_ch(c1),
        .out_valid(ov1), .out_ready(or1)
    );

    rr_mux_arb #(.N_CH(3), .WIDTH(8), .MODE(0)) u_m3 (
        .clk(clk), .rst_n(rst_n), .in_data(din3), .in_valid(v3),
        .in_ready(r3), .sel(s3), .out_data(d3o), .out_ch(c3),
        .out_valid(ov3), .out_ready(or3)
    );

    typedef struct {
        int         dut;
        logic [1:0] sel;
        logic [3:0] vld;
        logic       ordy;
        logic [3:0] rdy;
        int         och;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic [1:0] c;
    } word_t;

    vec_t  vecs[$];
    word_t q[$];
    int    checks = 0;
    int    errors = 0;
    logic  m_ov = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input int dut, input logic [1:0] sel,
                       input logic [3:0] vld, input logic ordy,
                       input logic [3:0] rdy, input int och);
        vec_t t;
        t.dut = dut; t.sel = sel; t.vld = vld;
        t.ordy = ordy; t.rdy = rdy; t.och = och;
        vecs.push_back(t);
    endtask

    initial begin
        // MODE 0: select, next select, invalid select, 1/0/1/1 drain.
        add(0, 2'd2, 4'hF, 1'b1, 4'b0100, -1);
        add(0, 2'd3, 4'hF, 1'b1, 4'b1000, 2);
        add(0, 2'd2, 4'hB, 1'b1, 4'b0100, 3);
        add(0, 2'd2, 4'hB, 1'b1, 4'b0100, -1);
        add(0, 2'd0, 4'hF, 1'b1, 4'b0001, -1);
        add(0, 2'd1, 4'hF, 1'b0, 4'b0000, 0);
        add(0, 2'd0, 4'hF, 1'b1, 4'b0001, 0);
        add(0, 2'd0, 4'hF, 1'b1, 4'b0001, 0);
        add(0, 2'd0, 4'h0, 1'b1, 4'b0001, 0);
        // MODE 1 fairness: all valid for 8 cycles.
        add(1, 2'd0, 4'hF, 1'b1, 4'b0001, -1);
        add(1, 2'd0, 4'hF, 1'b1, 4'b0010, 0);
        add(1, 2'd0, 4'hF, 1'b1, 4'b0100, 1);
        add(1, 2'd0, 4'hF, 1'b1, 4'b1000, 2);
        add(1, 2'd0, 4'hF, 1'b1, 4'b0001, 3);
        add(1, 2'd0, 4'hF, 1'b1, 4'b0010, 0);
        add(1, 2'd0, 4'hF, 1'b1, 4'b0100, 1);
        add(1, 2'd0, 4'hF, 1'b1, 4'b1000, 2);
        add(1, 2'd0, 4'h0, 1'b1, 4'b0000, 3);
        // MODE 1 sparse (ch1, ch3) with a 3-cycle stall.
        add(1, 2'd0, 4'hA, 1'b1, 4'b0010, -1);
        add(1, 2'd3, 4'hA, 1'b0, 4'b0000, 1);
        add(1, 2'd0, 4'hA, 1'b0, 4'b0000, 1);
        add(1, 2'd0, 4'hA, 1'b0, 4'b0000, 1);
        add(1, 2'd0, 4'hA, 1'b1, 4'b1000, 1);
        add(1, 2'd0, 4'hA, 1'b1, 4'b0010, 3);
        add(1, 2'd0, 4'h0, 1'b1, 4'b0000, 1);
        add(1, 2'd0, 4'h0, 1'b1, 4'b0000, -1);

        rst_n = 1'b0;
        din = 32'h44332211;
        v0 = 4'hF; s0 = 2'd0; or0 = 1'b1;
        v1 = 4'hF; s1 = 2'd0; or1 = 1'b1;
        din3 = 24'h332211; v3 = 3'h0; s3 = 2'd0; or3 = 1'b1;
        #2;
        chk("rst out_valid", {31'd0, ov0}, 0);
        chk("rst out_data", {24'd0, d0o}, 0);
        chk("rst out_ch", {30'd0, c0}, 0);
        chk("rst in_ready m0", {28'd0, r0}, 0);
        chk("rst in_ready m1", {28'd0, r1}, 0);
        v0 = 4'h0; v1 = 4'h0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int r = 0; r < vecs.size(); r++) begin
            vec_t       t;
            logic [3:0] rdy, acc;
            logic       ovv;
            logic [7:0] dat;
            logic [1:0] ch;
            word_t      w;
            t = vecs[r];
            @(posedge clk); #1;
            din = {8'h44 + 8'(r), 8'h33 + 8'(r),
                   8'h22 + 8'(r), 8'h11 + 8'(r)};
            v0  = (t.dut == 0) ? t.vld : 4'h0;
            s0  = (t.dut == 0) ? t.sel : 2'd0;
            or0 = (t.dut == 0) ? t.ordy : 1'b1;
            v1  = (t.dut == 1) ? t.vld : 4'h0;
            s1  = t.sel;
            or1 = (t.dut == 1) ? t.ordy : 1'b1;
            #1;
            rdy = (t.dut == 0) ? r0 : r1;
            ovv = (t.dut == 0) ? ov0 : ov1;
            dat = (t.dut == 0) ? d0o : d1o;
            ch  = (t.dut == 0) ? c0 : c1;
            chk($sformatf("row%0d in_ready", r), {28'd0, rdy}, {28'd0, t.rdy});
            chk($sformatf("row%0d out_valid", r), {31'd0, ovv}, {31'd0, m_ov});
            if (m_ov && q.size() > 0) begin
                chk($sformatf("row%0d out_data", r), {24'd0, dat}, {24'd0, q[0].d});
                chk($sformatf("row%0d out_ch", r), {30'd0, ch}, {30'd0, q[0].c});
            end
            if (t.och >= 0) begin
                chk($sformatf("row%0d held out_ch", r), {30'd0, ch}, t.och);
            end
            if (m_ov && t.ordy && q.size() > 0) begin
                void'(q.pop_front());
            end
            acc = t.rdy & t.vld;
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) begin
                    w.d = din[i*8 +: 8];
                    w.c = 2'(i);
                    q.push_back(w);
                end
            end
            m_ov = (acc != 4'h0) ? 1'b1 : (t.ordy ? 1'b0 : m_ov);
        end

        @(posedge clk); #1;
        chk("scoreboard empty", q.size(), 0);
        chk("m1 idle out_valid", {31'd0, ov1}, 0);

        // 3-channel build: out-of-range select grants nothing.
        s3 = 2'd3; v3 = 3'h7; or3 = 1'b1;
        #1;
        chk("n3 sel3 in_ready", {29'd0, r3}, 0);
        @(posedge clk); #1;
        chk("n3 sel3 out_valid", {31'd0, ov3}, 0);
        s3 = 2'd2;
        #1;
        chk("n3 sel2 in_ready", {29'd0, r3}, 32'h4);
        @(posedge clk); #1;
        v3 = 3'h0;
        chk("n3 sel2 out_valid", {31'd0, ov3}, 1);
        chk("n3 sel2 out_data", {24'd0, d3o}, 32'h33);

        // Reset while both DUTs hold a stalled word.
        v1 = 4'hF; or1 = 1'b0;
        v0 = 4'hF; s0 = 2'd1; or0 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre-rst m1 out_valid", {31'd0, ov1}, 1);
        chk("pre-rst m0 out_valid", {31'd0, ov0}, 1);
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", {31'd0, ov1}, 0);
        chk("async rst out_data", {24'd0, d1o}, 0);
        chk("async rst out_ch", {30'd0, c1}, 0);
        chk("async rst in_ready m1", {28'd0, r1}, 0);
        chk("async rst in_ready m0", {28'd0, r0}, 0);
        chk("async rst m0 out_valid", {31'd0, ov0}, 0);
        v0 = 4'h0; or0 = 1'b1; s0 = 2'd0;
        @(posedge clk); #1;
        chk("in rst out_valid", {31'd0, ov1}, 0);
        rst_n = 1'b1;
        or1 = 1'b1;
        din = 32'hD4C3B2A1;
        #1;
        chk("post-rst no early load", {31'd0, ov1}, 0);
        chk("post-rst first grant", {28'd0, r1}, 32'h1);
        @(posedge clk); #1;
        v1 = 4'h0;
        chk("post-rst out_valid", {31'd0, ov1}, 1);
        chk("post-rst out_ch", {30'd0, c1}, 0);
        chk("post-rst out_data", {24'd0, d1o}, 32'hA1);
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_mux_arb.md
Name: rr_mux_arb

Overview:
Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes on every input and on the output. In MODE 0, an external select picks the channel, as a registered, flow-controlled N:1 mux. In MODE 1, a round-robin arbiter picks among requesting channels. It sits between several producer streams and a single consumer, and provides one output register stage.

Parameters:
N_CH, 4, number of input channels (>=2)
WIDTH, 8, data width per channel
MODE, 0, 0 = select-driven mux, 1 = round-robin arbitration (sel ignored)
SELW, (N_CH>1 ? $clog2(N_CH) : 1), width of sel and out_ch (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  N_CH  per-channel data valid
in_ready  output  N_CH  per-channel accept; transfer on ch i when in_valid[i] && in_ready[i]
sel  input  SELW  channel select, used in MODE 0 only
out_data  output  WIDTH  registered output data
out_ch  output  SELW  index of channel that supplied out_data
out_valid  output  1  output data valid
out_ready  input  1  consumer accept; transfer when out_valid && out_ready

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately): out_valid=0, out_data=0, out_ch=0, RR pointer=N_CH-1 (so ch0 has first priority). in_ready is all-zero while rst_n is low.
- Output stage: a one-entry register. can_load = !out_valid || out_ready. This is a combinational path from out_ready to in_ready, by design.
- Grant vector (one-hot or zero):
  - MODE 0: grant[sel]=1 regardless of in_valid. If sel >= N_CH, there is no grant.
  - MODE 1: starting at pointer+1 and wrapping modulo N_CH, grant the first i with in_valid[i]=1. If no input is valid, there is no grant.
- in_ready[i] = grant[i] && can_load && rst_n. At most one in_ready bit is high per cycle.
- On an accepted input on ch i at edge t: out_data<=in_data[i], out_ch<=i, out_valid<=1. Data is visible the cycle after acceptance (latency 1).
- Output drained with no new accept: out_valid<=0. out_data and out_ch hold their last values.
- Simultaneous drain and accept: the register reloads and out_valid stays 1. Full throughput is one word per cycle.
- Stall (out_valid && !out_ready): out_data and out_ch are held stable and all in_ready are 0. Changes on sel or in_valid during the stall have no effect.
- RR pointer (MODE 1) updates to i only on an accepted transfer from ch i. It is unchanged when idle or stalled, so a waiting channel keeps its place.
- Fairness (MODE 1): with all N_CH channels continuously valid and out_ready=1, grants cycle 0,1,...,N_CH-1,0,... No channel waits more than N_CH-1 accepted transfers.
- MODE 0 with sel pointing at a non-valid channel: no transfer occurs. out_valid falls after any pending drain.
- No data is lost or duplicated. Each accepted input appears exactly once on the output, in acceptance order.
- Reset mid-operation: the held word is discarded and out_valid drops asynchronously. After rst_n rises, the first accept occurs no earlier than the first clock edge.
- All internal state is clocked on posedge clk / negedge rst_n. Outputs are glitch-free registers, except in_ready, which is combinational.

Test Plan:
- Reset: drive rst_n=0 mid-stream with out_valid=1 -> out_valid, out_data and out_ch go to 0 immediately and in_ready=0000. Release, then MODE 1 with all valid -> first grant is ch0.
- MODE 0 select: N_CH=4, WIDTH=8, in_data ch0..3 = 11,22,33,44, all valid, out_ready=1, sel=2 -> in_ready=0100 and, next cycle, out_data=0x33, out_ch=2. Set sel=3 -> following cycle out_data=0x44.
- MODE 0 invalid select: sel=2 with in_valid[2]=0 -> no transfer and out_valid=0 after drain. A parametrisation with N_CH=3 and sel=3 -> in_ready=000.
- MODE 1 fairness: all four channels valid for 8 cycles, out_ready=1 -> out_ch sequence 0,1,2,3,0,1,2,3 with one word per cycle.
- MODE 1 sparse plus stall: only ch1 and ch3 valid. After one grant to ch1, hold out_ready=0 for 3 cycles -> out_data and out_ch are held, in_ready=0000 and the pointer is held. Release -> next grant is ch3, then ch1.
- Back-to-back throughput: out_ready toggling 1,0,1,1 with a continuous valid source -> exactly 3 words delivered, in order, with no duplicates and no drops.
